// File: rtl/fs_ds_inst_buf_pkg.sv
// Shared constants for the fetch-to-decode instruction buffer.
package fs_ds_inst_buf_pkg;

    localparam int PC_WD_DEF   = 32;
    localparam int INST_WD_DEF = 32;
    localparam int DS_BUS_WD   = PC_WD_DEF + INST_WD_DEF;
    localparam int STALL_WD    = 6;

    // Stall vector bit positions
    localparam int STALL_IF = 0;
    localparam int STALL_ID = 1;

    // Instruction substituted for a fetch that faulted on alignment
    localparam logic [31:0] INST_NOP = 32'h0340_0000;

    // Occupancy counter width able to hold 0..depth inclusive
    function automatic int fifo_cnt_wd(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fs_ds_inst_buf_fifo.sv
// inst_hold_fifo: small synchronous circular FIFO that holds fetched
// {pc, inst} entries while decode is stalled. Pop and push may happen in
// the same cycle; a push into a full FIFO is only accepted alongside a pop.
module inst_hold_fifo #(
    parameter int WIDTH  = 64,
    parameter int DEPTH  = 2,
    parameter int CNT_WD = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [WIDTH-1:0]  din,
    output logic [WIDTH-1:0]  dout,
    output logic [CNT_WD-1:0] count,
    output logic              full,
    output logic              empty
);

    localparam int PTR_WD = $clog2(DEPTH);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [PTR_WD-1:0] wr_ptr;
    logic [PTR_WD-1:0] rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CNT_WD'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Storage write; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at DEPTH (power of two)
    always_ff @(posedge clk) begin
        if (!resetn || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_WD'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_WD'(1);
            end
            count <= count + CNT_WD'(do_push) - CNT_WD'(do_pop);
        end
    end

endmodule

// File: rtl/fs_ds_inst_buf.sv
// fs_ds_inst_buf: pairs each issued fetch PC with the SRAM read data that
// returns one cycle later and presents a registered {pc, inst} bundle to
// decode. Responses arriving while decode is stalled wait in a hold FIFO.
// Optional build macro FETCH_ADEF_CHK_EN tags misaligned fetches: their
// instruction is replaced by a NOP and ds_adef is raised alongside it.
module fs_ds_inst_buf #(
    parameter int PC_WD     = 32,
    parameter int INST_WD   = 32,
    parameter int BUF_DEPTH = 2,
    parameter int DS_BUS_WD = PC_WD + INST_WD
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 flush,
    input  logic [5:0]           stall,
    input  logic                 inst_sram_en,
    input  logic [PC_WD-1:0]     fs_pc,
    input  logic [INST_WD-1:0]   inst_sram_rdata,
    output logic                 ds_valid,
    output logic [DS_BUS_WD-1:0] ds_bus,
    output logic                 ds_adef,
    output logic                 buf_full
);

    import fs_ds_inst_buf_pkg::*;

`ifdef FETCH_ADEF_CHK_EN
    localparam int ENTRY_WD = DS_BUS_WD + 1;
`else
    localparam int ENTRY_WD = DS_BUS_WD;
`endif
    localparam int CNT_WD = fifo_cnt_wd(BUF_DEPTH);

    logic                 issue;
    logic                 rsp_pend;
    logic [PC_WD-1:0]     rsp_pc;
    logic [ENTRY_WD-1:0]  arr_entry;
    logic [ENTRY_WD-1:0]  head_entry;
    logic [DS_BUS_WD-1:0] arr_bus;
    logic [DS_BUS_WD-1:0] head_bus;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_empty;
    logic [CNT_WD-1:0]    fifo_count;
    logic                 decode_go;
    logic                 unused_ok;

    // Re-reads under fetch stall and the forced read in a flush cycle are not real issues
    assign issue     = inst_sram_en && !stall[STALL_IF] && !flush;
    assign decode_go = !stall[STALL_ID];

    // Bypass the FIFO only when decode can take the response and nothing older is queued
    assign fifo_pop  = !flush && decode_go && !fifo_empty;
    assign fifo_push = !flush && rsp_pend && (!decode_go || !fifo_empty);

    assign unused_ok = ^{stall[5:2], fifo_count};

    // Track the one outstanding SRAM response and the PC it belongs to
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rsp_pend <= 1'b0;
            rsp_pc   <= '0;
        end else begin
            rsp_pend <= issue;
            if (issue) begin
                rsp_pc <= fs_pc;
            end
        end
    end

`ifdef FETCH_ADEF_CHK_EN
    logic rsp_adef;
    logic arr_adef;
    logic head_adef;

    // Remember whether the outstanding request was misaligned
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rsp_adef <= 1'b0;
        end else if (issue) begin
            rsp_adef <= (fs_pc[1:0] != 2'b00);
        end
    end

    assign arr_adef   = rsp_adef;
    assign arr_bus    = {rsp_pc, rsp_adef ? INST_WD'(INST_NOP) : inst_sram_rdata};
    assign arr_entry  = {arr_adef, arr_bus};
    assign head_adef  = head_entry[ENTRY_WD-1];
    assign head_bus   = head_entry[DS_BUS_WD-1:0];

    // Fault flag travels with the bundle through the same load decisions
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ds_adef <= 1'b0;
        end else if (flush) begin
            ds_adef <= 1'b0;
        end else if (decode_go) begin
            if (!fifo_empty) begin
                ds_adef <= head_adef;
            end else if (rsp_pend) begin
                ds_adef <= arr_adef;
            end else begin
                ds_adef <= 1'b0;
            end
        end
    end
`else
    assign arr_bus   = {rsp_pc, inst_sram_rdata};
    assign arr_entry = arr_bus;
    assign head_bus  = head_entry;
    assign ds_adef   = 1'b0;
`endif

    inst_hold_fifo #(
        .WIDTH  (ENTRY_WD),
        .DEPTH  (BUF_DEPTH),
        .CNT_WD (CNT_WD)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .flush  (flush),
        .push   (fifo_push),
        .pop    (fifo_pop),
        .din    (arr_entry),
        .dout   (head_entry),
        .count  (fifo_count),
        .full   (buf_full),
        .empty  (fifo_empty)
    );

    // Decode output register: queued entries go first to keep program order
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ds_valid <= 1'b0;
            ds_bus   <= '0;
        end else if (flush) begin
            ds_valid <= 1'b0;
        end else if (decode_go) begin
            if (!fifo_empty) begin
                ds_valid <= 1'b1;
                ds_bus   <= head_bus;
            end else if (rsp_pend) begin
                ds_valid <= 1'b1;
                ds_bus   <= arr_bus;
            end else begin
                ds_valid <= 1'b0;
            end
        end
    end

`ifndef SYNTHESIS
    a_no_push_when_full: assert property (@(posedge clk) disable iff (!resetn)
        !(fifo_push && buf_full && !fifo_pop));
`endif

endmodule

// File: tb/tb_fs_ds_inst_buf.sv
// Directed bench for fs_ds_inst_buf: back-to-back fetch, decode stall,
// fetch stall re-reads, FIFO fill/drain, flush, reset and misaligned PC.
module tb_fs_ds_inst_buf;

    logic        clk;
    logic        resetn;
    logic        flush;
    logic [5:0]  stall;
    logic        inst_sram_en;
    logic [31:0] fs_pc;
    logic [31:0] inst_sram_rdata;
    logic        ds_valid;
    logic [63:0] ds_bus;
    logic        ds_adef;
    logic        buf_full;

    int n_checks;
    int n_errors;

    fs_ds_inst_buf #(
        .PC_WD     (32),
        .INST_WD   (32),
        .BUF_DEPTH (2),
        .DS_BUS_WD (64)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .flush           (flush),
        .stall           (stall),
        .inst_sram_en    (inst_sram_en),
        .fs_pc           (fs_pc),
        .inst_sram_rdata (inst_sram_rdata),
        .ds_valid        (ds_valid),
        .ds_bus          (ds_bus),
        .ds_adef         (ds_adef),
        .buf_full        (buf_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, then settle just after the active edge
    task automatic cyc(input logic en, input logic [31:0] pc, input logic [31:0] rd,
                       input logic [1:0] st, input logic fl);
        inst_sram_en    = en;
        fs_pc           = pc;
        inst_sram_rdata = rd;
        stall           = {4'b0000, st};
        flush           = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        resetn   = 1'b0;

        // Reset
        cyc(1'b1, 32'h1c00_0000, 32'hdead_beef, 2'b00, 1'b0);
        cyc(1'b1, 32'h1c00_0000, 32'hdead_beef, 2'b00, 1'b0);
        chk("rst_valid", ds_valid, 0);
        chk("rst_bus",   ds_bus, 0);
        chk("rst_adef",  ds_adef, 0);
        chk("rst_full",  buf_full, 0);
        resetn = 1'b1;

        // Back-to-back issue, no stalls
        cyc(1'b1, 32'h1c00_0000, 32'h0, 2'b00, 1'b0);
        chk("b2b_valid0", ds_valid, 0);
        cyc(1'b1, 32'h1c00_0004, 32'h0280_0401, 2'b00, 1'b0);
        chk("b2b_valid1", ds_valid, 1);
        chk("b2b_bus1",   ds_bus, {32'h1c00_0000, 32'h0280_0401});
        cyc(1'b0, 32'h1c00_0008, 32'h0280_0802, 2'b00, 1'b0);
        chk("b2b_bus2",   ds_bus, {32'h1c00_0004, 32'h0280_0802});
        chk("b2b_valid2", ds_valid, 1);
        cyc(1'b0, 32'h1c00_0008, 32'h0, 2'b00, 1'b0);
        chk("b2b_drain",  ds_valid, 0);

        // Stall 2'b11 for three cycles in the response cycle
        cyc(1'b1, 32'h1c00_0000, 32'h0, 2'b00, 1'b0);
        cyc(1'b1, 32'h1c00_0004, 32'h0280_0401, 2'b11, 1'b0);
        chk("stl_cnt0",   dut.fifo_count, 1);
        chk("stl_valid0", ds_valid, 0);
        for (int i = 0; i < 2; i++) begin
            cyc(1'b1, 32'h1c00_0004, 32'h0280_0401, 2'b11, 1'b0);
            chk("stl_frozen", {ds_valid, 5'b0, dut.fifo_count}, {1'b0, 5'b0, 2'd1});
        end
        cyc(1'b1, 32'h1c00_0004, 32'h1111_1111, 2'b00, 1'b0);
        chk("stl_rel_bus", ds_bus, {32'h1c00_0000, 32'h0280_0401});
        chk("stl_rel_cnt", dut.fifo_count, 0);
        cyc(1'b0, 32'h1c00_0008, 32'h0280_0802, 2'b00, 1'b0);
        chk("stl_next_bus", ds_bus, {32'h1c00_0004, 32'h0280_0802});
        chk("stl_next_vld", ds_valid, 1);
        cyc(1'b0, 32'h1c00_0008, 32'h0, 2'b00, 1'b0);
        chk("stl_no_dup", ds_valid, 0);

        // Fetch stall re-reads are not issues
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 32'h1c00_0008, 32'h2222_2222, 2'b01, 1'b0);
            chk("rr_cnt", dut.fifo_count, 0);
        end
        cyc(1'b0, 32'h1c00_0008, 32'h2222_2222, 2'b00, 1'b0);
        chk("rr_valid", ds_valid, 0);

        // Fill FIFO to full, then drain with concurrent push+pop
        cyc(1'b1, 32'h1c00_0010, 32'h0, 2'b00, 1'b0);
        cyc(1'b1, 32'h1c00_0014, 32'ha000_0010, 2'b10, 1'b0);
        chk("fill_cnt1", dut.fifo_count, 1);
        cyc(1'b1, 32'h1c00_0018, 32'ha000_0014, 2'b10, 1'b0);
        chk("fill_full", buf_full, 1);
        chk("fill_hold", ds_valid, 0);
        cyc(1'b1, 32'h1c00_001c, 32'ha000_0018, 2'b01, 1'b0);
        chk("drain0_bus", ds_bus, {32'h1c00_0010, 32'ha000_0010});
        chk("drain0_full", buf_full, 1);
        cyc(1'b1, 32'h1c00_001c, 32'h3333_3333, 2'b01, 1'b0);
        chk("drain1_bus", ds_bus, {32'h1c00_0014, 32'ha000_0014});
        chk("drain1_cnt", dut.fifo_count, 1);
        cyc(1'b1, 32'h1c00_001c, 32'h3333_3333, 2'b00, 1'b0);
        chk("drain2_bus", ds_bus, {32'h1c00_0018, 32'ha000_0018});
        chk("drain2_cnt", dut.fifo_count, 0);
        cyc(1'b0, 32'h1c00_0020, 32'ha000_001c, 2'b00, 1'b0);
        chk("drain3_bus", ds_bus, {32'h1c00_001c, 32'ha000_001c});
        chk("drain3_vld", ds_valid, 1);
        cyc(1'b0, 32'h1c00_0020, 32'h0, 2'b00, 1'b0);
        chk("drain_end", ds_valid, 0);

        // Flush with a full FIFO and a response arriving
        cyc(1'b1, 32'h1c00_0040, 32'h0, 2'b00, 1'b0);
        cyc(1'b1, 32'h1c00_0044, 32'hb000_0040, 2'b00, 1'b0);
        chk("fl_pre_bus", ds_bus, {32'h1c00_0040, 32'hb000_0040});
        cyc(1'b1, 32'h1c00_0048, 32'hb000_0044, 2'b10, 1'b0);
        cyc(1'b1, 32'h1c00_004c, 32'hb000_0048, 2'b10, 1'b0);
        chk("fl_pre_full", buf_full, 1);
        chk("fl_pre_vld",  ds_valid, 1);
        cyc(1'b1, 32'h1c00_0100, 32'hb000_004c, 2'b10, 1'b1);
        chk("fl_valid", ds_valid, 0);
        chk("fl_cnt",   dut.fifo_count, 0);
        chk("fl_full",  buf_full, 0);
        cyc(1'b1, 32'h1c00_0100, 32'h0, 2'b00, 1'b0);
        chk("fl_drop", ds_valid, 0);
        cyc(1'b0, 32'h1c00_0104, 32'h0280_0c03, 2'b00, 1'b0);
        chk("fl_post_bus", ds_bus, {32'h1c00_0100, 32'h0280_0c03});
        chk("fl_post_vld", ds_valid, 1);

        // Reset in a response cycle discards everything
        cyc(1'b1, 32'h1c00_0200, 32'h0, 2'b00, 1'b0);
        resetn = 1'b0;
        cyc(1'b0, 32'h1c00_0204, 32'h4444_4444, 2'b00, 1'b0);
        chk("mrst_valid", ds_valid, 0);
        chk("mrst_bus",   ds_bus, 0);
        resetn = 1'b1;
        cyc(1'b0, 32'h1c00_0204, 32'h4444_4444, 2'b00, 1'b0);
        chk("mrst_stale", ds_valid, 0);

        // Misaligned fetch PC
        cyc(1'b1, 32'h1c00_0002, 32'h0, 2'b00, 1'b0);
        cyc(1'b0, 32'h1c00_0004, 32'h0280_0c03, 2'b00, 1'b0);
        chk("adef_vld", ds_valid, 1);
`ifdef FETCH_ADEF_CHK_EN
        chk("adef_bus",  ds_bus, {32'h1c00_0002, 32'h0340_0000});
        chk("adef_flag", ds_adef, 1);
`else
        chk("adef_bus",  ds_bus, {32'h1c00_0002, 32'h0280_0c03});
        chk("adef_flag", ds_adef, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fs_ds_inst_buf.md
Name: fs_ds_inst_buf

Overview:
- Sits between the fetch stage and the decode stage.
- Pairs each fetch PC with the instruction SRAM read data, which returns one cycle after the request. Presents a registered {pc, inst} bundle with a valid bit to decode.
- Absorbs responses that arrive while decode is stalled in a small FIFO, so no fetched instruction is lost or duplicated.
- Discards in-flight work on pipeline flush.

Parameters:
- PC_WD, 32, PC / address width.
- INST_WD, 32, instruction width.
- BUF_DEPTH, 2, hold-FIFO entries; power of two, >=2.
- DS_BUS_WD, 64, width of the output bundle; equals PC_WD+INST_WD.

Ports:
- clk  in  1  clock; all state updates on posedge.
- resetn  in  1  synchronous, active-low reset.
- flush  in  1  pipeline flush (exception/ertn redirect).
- stall  in  6  per-stage stall; stall[0]=fetch, stall[1]=decode.
- inst_sram_en  in  1  fetch request strobe, as driven to the SRAM.
- fs_pc  in  PC_WD  fetch PC: the fetch-to-decode bus, equal to the SRAM address this cycle.
- inst_sram_rdata  in  INST_WD  SRAM read data, valid the cycle after an issued request.
- ds_valid  out  1  output bundle holds a live instruction.
- ds_bus  out  DS_BUS_WD  {pc, inst}, pc in the MSBs.
- ds_adef  out  1  fetch-address-error flag (optional feature).
- buf_full  out  1  hold FIFO full; fed to the stall controller.

Behaviour:
- Issue rule:
  - A request is "issued" in a cycle iff inst_sram_en=1 && stall[0]=0 && flush=0.
  - Requests made under stall[0] are re-reads of the same PC and are ignored.
  - The forced request made in a flush cycle is discarded.
- Response tracking:
  - rsp_pend is set on the clock edge after an issue, and rsp_pc latches fs_pc.
  - rsp_pend clears on the next edge unless another request issues.
  - In the cycle rsp_pend=1, {rsp_pc, inst_sram_rdata} is the "arriving response".
- Output register update (decode advances when stall[1]=0):
  - flush=1: ds_valid<=0, FIFO emptied, rsp_pend<=0; the arriving response is dropped. Flush beats every other event.
  - stall[1]=0 and FIFO non-empty: load head entry into ds_bus, ds_valid<=1, pop. The arriving response, if any, is pushed in the same cycle (simultaneous push+pop is legal).
  - stall[1]=0, FIFO empty, response arriving: load it directly, ds_valid<=1. Zero added latency: data at edge N+1 after issue in cycle N.
  - stall[1]=0, nothing available: ds_valid<=0.
  - stall[1]=1: ds_bus/ds_valid hold; an arriving response is pushed to the FIFO.
- FIFO: circular, wr/rd pointers plus count, wraps modulo BUF_DEPTH. Ordering is strictly program order.
- buf_full=1 when count==BUF_DEPTH.
  - The stall controller keeps stall[0] asserted while buf_full, so no push occurs when full.
  - A push when full and not popping is a protocol violation: the entry is dropped and a simulation-only assertion fires.
- Reset (resetn=0 at posedge): ds_valid=0, ds_bus=0, ds_adef=0, buf_full=0, rsp_pend=0, pointers/count=0. Reset mid-operation discards everything.

Optional Feature:
- Macro: FETCH_ADEF_CHK_EN.
- Defined:
  - An issued request with fs_pc[1:0]!=0 is tagged adef.
  - Its response is carried with inst replaced by NOP 32'h0340_0000 and ds_adef=1 alongside it; the adef bit is stored in the FIFO entry.
- Undefined: ds_adef tied to 0 and no extra FIFO bit.

Decomposition:
- Shared package/header: INST_NOP constant, DS_BUS_WD, stall index constants (STALL_IF=0, STALL_ID=1).
- One sub-module, inst_hold_fifo: parameterised sync FIFO (push/pop/flush/count/full/empty). The top does issue tracking and output register.

Test Plan:
- Reset then issue pcs 0x1c000000, 0x1c000004 back-to-back with rdata 0x02800401, 0x02800802, no stalls -> ds_valid high from the 2nd edge; ds_bus shows each pair one cycle after its issue.
- Issue 0x1c000000, assert stall[1:0]=2'b11 for 3 cycles in the response cycle -> ds_valid/ds_bus frozen; FIFO count=1; on release pc 0x1c000000 delivered once, then the next pc with no gap or duplicate.
- Hold stall[0]=1 with inst_sram_en=1 for 4 cycles on pc 0x1c000008 -> no pushes, count unchanged, ds_valid=0 after drain.
- Fill the FIFO to 2 (staggered stall[1]-only stalls) -> buf_full=1; release -> entries drain in order, one per cycle, concurrent push+pop preserves order.
- Flush in a response cycle with FIFO count=2 -> next cycle ds_valid=0, count=0; response dropped; first post-flush issue appears 1 cycle later.
- FETCH_ADEF_CHK_EN defined, issue pc 0x1c000002 -> ds_adef=1, inst=0x03400000; undefined -> ds_adef=0, raw rdata passed.
